// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared definitions for the decoder round-robin arbiter.
//   state_e     : FSM state encoding (IDLE / GRANT)
//   N_DEF       : default number of requesters (power of two)
//   IDX_W_DEF   : default index width, log2(N_DEF)
//   onehot(idx) : one-hot vector of N_DEF bits with bit idx set
package decoder_rr_arbiter_pkg;

  localparam int N_DEF     = 8;
  localparam int IDX_W_DEF = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [N_DEF-1:0] onehot(input logic [IDX_W_DEF-1:0] idx);
    logic [N_DEF-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
//   iReq      : level request vector, one bit per requester
//   oGrant    : registered one-hot grant (all zero when idle)
//   oGrantIdx : index of the granted requester (decoder select)
//   oValid    : grant present (decoder enable)
//   dbg_state : arbiter FSM state, for observation only
//   dbg_ptr   : round-robin start pointer, for observation only
// Handshake: a requester raises iReq[k] and keeps it high for as long as it
// needs the resource; it owns the resource in every cycle where oValid=1 and
// oGrantIdx=k. Dropping iReq[k] releases (or withdraws) the request; the
// arbiter reacts on the next clock edge. There is no ready/backpressure.
// Modports: master = requester side, slave = arbiter side.
interface decoder_rr_arbiter_if
  import decoder_rr_arbiter_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = IDX_W_DEF
);

  logic [N-1:0]     iReq;
  logic [N-1:0]     oGrant;
  logic [IDX_W-1:0] oGrantIdx;
  logic             oValid;
  state_e           dbg_state;
  logic [IDX_W-1:0] dbg_ptr;

  modport master (
    output iReq,
    input  oGrant, oGrantIdx, oValid, dbg_state, dbg_ptr
  );

  modport slave (
    input  iReq,
    output oGrant, oGrantIdx, oValid, dbg_state, dbg_ptr
  );

endinterface

// File: rtl/decoder_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i      : request vector
//   start_i    : first index to consider; scan wraps modulo N
//   excl_en_i  : when set, excl_idx_i is never picked
//   excl_idx_i : index to exclude (current owner on handover/preempt)
//   found_o    : some eligible request exists
//   idx_o      : first eligible index in scan order
module decoder_rr_arbiter_rr_pick
  import decoder_rr_arbiter_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] start_i,
  input  logic             excl_en_i,
  input  logic [IDX_W-1:0] excl_idx_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  // Scan from the far end back toward start, so the last hit written is the
  // one nearest to start. Index arithmetic wraps because N == 2**IDX_W.
  always_comb begin
    logic [IDX_W-1:0] cand;
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = start_i + IDX_W'(k);
      if (req_i[cand] && !(excl_en_i && (cand == excl_idx_i))) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter that shares a 3-to-8 decoder among N requesters.
// Grants one requester at a time, holds the grant while the owner keeps its
// request high, hands over with no idle cycle when the owner releases, and
// preempts an owner that has held for MAX_HOLD cycles while others wait.
//   clk : rising-edge clock
//   rst : asynchronous reset, active-high
//   bus : decoder_rr_arbiter_if.slave (iReq in; oGrant/oGrantIdx/oValid and
//         debug state/pointer out, all registered)
module decoder_rr_arbiter
  import decoder_rr_arbiter_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int MAX_HOLD = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  decoder_rr_arbiter_if.slave   bus
);

  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic [N-1:0]     grant_q, grant_d;

  logic [IDX_W-1:0] pick_start;
  logic             pick_excl_en;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_req;
  logic             hold_expired;

  // While granting, the scan starts just past the owner and skips it, so the
  // owner is the lowest priority on a handover or preempt edge.
  assign pick_start   = (state_q == ST_GRANT) ? idx_q + IDX_W'(1) : ptr_q;
  assign pick_excl_en = (state_q == ST_GRANT);

  decoder_rr_arbiter_rr_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i      (bus.iReq),
    .start_i    (pick_start),
    .excl_en_i  (pick_excl_en),
    .excl_idx_i (idx_q),
    .found_o    (pick_found),
    .idx_o      (pick_idx)
  );

  assign owner_req = bus.iReq[idx_q];

  // ">=" rather than "==": once the counter has saturated with no contender,
  // the first contender to arrive preempts on the next edge instead of
  // waiting forever.
  assign hold_expired = (MAX_HOLD != 0) && (cnt_q >= HOLD_LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          idx_d   = pick_idx;
          valid_d = 1'b1;
          ptr_d   = pick_idx + IDX_W'(1);
          cnt_d   = '0;
        end
      end

      ST_GRANT: begin
        if (!owner_req || (hold_expired && pick_found)) begin
          if (pick_found) begin
            idx_d = pick_idx;
            ptr_d = pick_idx + IDX_W'(1);
            cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end else if (cnt_q != HOLD_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    grant_d = valid_d ? (N'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
    end
  end

  assign bus.oGrant    = grant_q;
  assign bus.oGrantIdx = idx_q;
  assign bus.oValid    = valid_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
module tb_decoder_rr_arbiter;
  import decoder_rr_arbiter_pkg::*;

  localparam int N          = 8;
  localparam int IDX_W      = 3;
  localparam int MAX_HOLD   = 4;
  localparam int STARVE_MAX = (N - 1) * MAX_HOLD + N;
  localparam int RAND_CYC   = 10000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decoder_rr_arbiter_if #(.N(N), .IDX_W(IDX_W)) bus ();

  decoder_rr_arbiter #(
    .N        (N),
    .IDX_W    (IDX_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  // Owner -1 means idle; held counts cycles the current owner has shown.
  int m_owner;
  int m_ptr;
  int m_held;

  function automatic int pick(input logic [7:0] r, input int start, input int excl);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
  endtask

  task automatic model_give(input int p);
    m_owner = p;
    m_ptr   = (p + 1) % N;
    m_held  = 1;
  endtask

  task automatic model_step(input logic [7:0] r);
    int p;
    if (m_owner < 0) begin
      p = pick(r, m_ptr, -1);
      if (p >= 0) model_give(p);
    end else if (!r[m_owner]) begin
      p = pick(r, m_owner + 1, m_owner);
      if (p >= 0) model_give(p);
      else m_owner = -1;
    end else begin
      p = pick(r, m_owner + 1, m_owner);
      if (m_held >= MAX_HOLD && p >= 0) model_give(p);
      else m_held++;
    end
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic exp_v, input logic [2:0] exp_i);
    logic [7:0] exp_g;
    exp_g = exp_v ? (8'd1 << exp_i) : 8'd0;
    check({tag, ".valid"}, 32'(bus.oValid), 32'(exp_v));
    check({tag, ".grant"}, 32'(bus.oGrant), 32'(exp_g));
    if (exp_v) check({tag, ".idx"}, 32'(bus.oGrantIdx), 32'(exp_i));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic [7:0] r);
    bus.iReq = r;
    model_step(r);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.iReq = '0;
    rst = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0] req;
    logic       exp_v;
    logic [2:0] exp_i;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] r, input logic v, input logic [2:0] i);
    vec_t t;
    t.req = r; t.exp_v = v; t.exp_i = i;
    vecs.push_back(t);
  endtask

  initial begin
    int g;
    int max_wait;
    int wait_cnt[N];
    logic [7:0] r;

    bus.iReq = '0;

    // Reset state
    do_reset();
    check_out("reset", 1'b0, 3'd0);
    check("reset.idx0", 32'(bus.oGrantIdx), 32'd0);
    check("reset.ptr", 32'(bus.dbg_ptr), 32'd0);
    check("reset.state", 32'(bus.dbg_state), 32'(ST_IDLE));

    // Table: handover, idle, wrap/exclusion, re-raise, timeout, indefinite hold
    add(8'h24, 1, 2); add(8'h20, 1, 5); add(8'h00, 0, 0);
    add(8'h41, 1, 6); add(8'h01, 1, 0); add(8'h00, 0, 0);
    add(8'h03, 1, 1); add(8'h01, 1, 0); add(8'h03, 1, 0);
    add(8'h02, 1, 1); add(8'h00, 0, 0);
    for (int i = 0; i < 4; i++) add(8'h81, 1, 7);
    for (int i = 0; i < 4; i++) add(8'h81, 1, 0);
    add(8'h81, 1, 7);
    for (int i = 0; i < 10; i++) add(8'h01, 1, 0);
    add(8'h81, 1, 7);
    add(8'h00, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].req);
      check_out($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_i);
    end

    // Reset in the middle of a grant
    do_reset();
    cycle(8'h08);
    check_out("rstmid.pre", 1'b1, 3'd3);
    check("rstmid.preptr", 32'(bus.dbg_ptr), 32'd4);
    #2 rst = 1'b1;
    #1;
    check_out("rstmid.async", 1'b0, 3'd0);
    check("rstmid.idx", 32'(bus.oGrantIdx), 32'd0);
    check("rstmid.ptr", 32'(bus.dbg_ptr), 32'd0);
    #2 rst = 1'b0;
    model_reset();
    cycle(8'h08);
    check_out("rstmid.post", 1'b1, 3'd3);

    // Rotation: all requesting, owner drops for one cycle when granted
    do_reset();
    cycle(8'hFF);
    check_out("rot0", 1'b1, 3'd0);
    g = 0;
    for (int i = 1; i <= N; i++) begin
      r = 8'hFF;
      r[g] = 1'b0;
      cycle(r);
      g = (g + 1) % N;
      check_out($sformatf("rot%0d", i), 1'b1, 3'(g));
    end

    // Random stimulus against the model, with invariants and starvation
    do_reset();
    r = '0;
    max_wait = 0;
    for (int k = 0; k < N; k++) wait_cnt[k] = 0;
    for (int c = 0; c < RAND_CYC; c++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 7) == 0) r[k] = ~r[k];
      cycle(r);
      check_out("rand", (m_owner >= 0), 3'(m_owner < 0 ? 0 : m_owner));
      check("inv.onehot0", 32'($onehot0(bus.oGrant)), 32'd1);
      check("inv.valid", 32'(bus.oValid), 32'(|bus.oGrant));
      if (bus.oValid)
        check("inv.idx", 32'(bus.oGrant), 32'(8'd1 << bus.oGrantIdx));
      for (int k = 0; k < N; k++) begin
        if (r[k] && !(bus.oValid && bus.oGrantIdx == 3'(k))) wait_cnt[k]++;
        else wait_cnt[k] = 0;
        if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
      end
    end
    check("starve.maxwait_ok", 32'(max_wait <= STARVE_MAX), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
